// File: rtl/not_pipe_pkg.sv
// not_pipe_pkg: default sizes and the per-bit not/buf transform shared by the pipeline
package not_pipe_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_STAGES = 2;
  localparam int DEF_CNT_W = 16;
  // XOR acts as not (m=1) or buf (m=0); an x or z input bit comes out as x
  function automatic logic xform_bit(logic d, logic m);
    return d ^ m;
  endfunction
endpackage

// File: rtl/not_pipe_stage.sv
// not_pipe_stage: one valid/data register slice with ready/valid handshake
module not_pipe_stage import not_pipe_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  output logic             up_ready,
  output logic             dn_valid,
  output logic [WIDTH-1:0] dn_data,
  input  logic             dn_ready
);
  assign up_ready = !dn_valid || dn_ready;
  // load from upstream whenever empty or the downstream takes the held item
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      dn_valid <= 1'b0;
      dn_data  <= '0;
    end else if (up_ready) begin
      dn_valid <= up_valid;
      if (up_valid) dn_data <= up_data;
    end
endmodule

// File: rtl/not_pipe.sv
// not_pipe: masked not/buf channels through a STAGES-deep elastic pipeline with change counter
module not_pipe import not_pipe_pkg::*; #(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [WIDTH-1:0] mask,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] chg_cnt,
  output logic             xz_flag
);
  logic [WIDTH-1:0] xf;
  logic [WIDTH-1:0] last;
  logic accept, xfer;
  // transform once, ahead of stage 1, with the mask sampled on the same accept
  always_comb
    for (int i = 0; i < WIDTH; i++) xf[i] = xform_bit(in_data[i], mask[i]);
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic up_v, up_r, dn_v, dn_r;
    logic [WIDTH-1:0] up_d, dn_d;
    if (k == 0) begin : g_head
      assign up_v = in_valid;
      assign up_d = xf;
      assign in_ready = up_r;
    end else begin : g_link
      assign up_v = g_stage[k-1].dn_v;
      assign up_d = g_stage[k-1].dn_d;
    end
    if (k == STAGES - 1) begin : g_tail
      assign dn_r = out_ready;
      assign out_valid = dn_v;
      assign out_data = dn_d;
    end else begin : g_mid
      assign dn_r = g_stage[k+1].up_r;
    end
    not_pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk(clk),
      .rst_n(rst_n),
      .up_valid(up_v),
      .up_data(up_d),
      .up_ready(up_r),
      .dn_valid(dn_v),
      .dn_data(dn_d),
      .dn_ready(dn_r)
    );
  end
  assign accept = in_valid && in_ready;
  assign xfer = out_valid && out_ready;
  // saturating count of changing transfers and sticky x/z flag; clr overrides both
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      chg_cnt <= '0;
      xz_flag <= 1'b0;
      last    <= '0;
    end else if (clr) begin
      chg_cnt <= '0;
      xz_flag <= 1'b0;
      last    <= '0;
    end else begin
      if (xfer) begin
        last <= out_data;
        if (out_data !== last && chg_cnt != '1) chg_cnt <= chg_cnt + CNT_W'(1);
      end
      if (accept && $isunknown(in_data)) xz_flag <= 1'b1;
    end
endmodule
